// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed N-digit display scanner. A prescaler holds each digit for PRESCALE clocks
//   while a digit index walks 0..NUM_DIGITS-1. New display data is applied only at the frame
//   boundary, so a frame is never torn. The block also does leading-zero blanking and per-digit
//   blinking.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   code_in       in   digit codes, digit i = code_in[4i+3:4i]
//   load          in   1-cycle request to capture code_in (applied at the next frame boundary)
//   blank_lz      in   1: suppress leading zeros
//   blink_mask    in   1: digit i blinks (sampled live)
//   digit_select  out  one-hot digit strobe, active-low when SEL_ACTIVE_LOW = 1
//   out           out  4-bit code of the selected digit
//   blank         out  1: all segments off for this digit
//   frame_tick    out  1-cycle pulse in the first cycle digit 0 is shown after a wrap
module display_scan_ctrl #(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned PRESCALE       = 1000,
   parameter int unsigned BLINK_DIV      = 256,
   parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] code_in,
   input  logic                    load,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [NUM_DIGITS-1:0]   digit_select,
   output logic [3:0]              out,
   output logic                    blank,
   output logic                    frame_tick
);

   localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
   localparam int unsigned PrescW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_DIGITS - 1);
   localparam logic [PrescW-1:0] PrescLast = PrescW'(PRESCALE - 1);
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

   localparam logic [NUM_DIGITS-1:0] SelIdle = {NUM_DIGITS{SEL_ACTIVE_LOW}};

   // Scan state
   logic [PrescW-1:0] presc_q, presc_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
   logic              blink_phase_q, blink_phase_d;
   logic              wrap_q;

   // Display data
   logic [NUM_DIGITS-1:0][3:0] disp_q, disp_d;
   logic [NUM_DIGITS-1:0][3:0] pend_q, pend_d;
   logic                       pend_valid_q, pend_valid_d;

   // Registered outputs
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic [3:0]            out_q, out_d;
   logic                  blank_q, blank_d;
   logic                  frame_tick_q;

   logic                  presc_last;
   logic                  wrap;
   logic [NUM_DIGITS-1:0] lz_blank;

   assign presc_last = (presc_q == PrescLast);
   assign wrap       = presc_last && (idx_q == IdxLast);

   // Prescaler, index and blink sequencing
   always_comb begin
      presc_d       = presc_q;
      idx_d         = idx_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;

      if (presc_last) begin
         presc_d = '0;
         idx_d   = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
      end else begin
         presc_d = presc_q + PrescW'(1);
      end

      if (wrap) begin
         if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
         end
      end
   end

   // Frame-synchronous load: a load at the wrap takes priority over anything pending
   always_comb begin
      disp_d       = disp_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;

      if (wrap) begin
         if (load) begin
            disp_d = code_in;
         end else if (pend_valid_q) begin
            disp_d = pend_q;
         end
         pend_valid_d = 1'b0;
      end else if (load) begin
         pend_d       = code_in;
         pend_valid_d = 1'b1;
      end
   end

   // Output decode for the current index
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      lz_blank = '0;
      // Walk down from the most significant digit; a digit is leading-zero while every digit
      // from the top down to it is zero. Digit 0 always shows.
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (disp_q[i] == 4'h0);
         if (i != 0) begin
            lz_blank[i] = blank_lz && zero_run;
         end
      end

      sel_d        = '0;
      sel_d[idx_q] = 1'b1;
      if (SEL_ACTIVE_LOW) begin
         sel_d = ~sel_d;
      end

      out_d   = disp_q[idx_q];
      blank_d = lz_blank[idx_q] || (blink_mask[idx_q] && blink_phase_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q       <= '0;
         idx_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         wrap_q        <= 1'b0;
         disp_q        <= '0;
         pend_q        <= '0;
         pend_valid_q  <= 1'b0;
         sel_q         <= SelIdle;
         out_q         <= 4'h0;
         blank_q       <= 1'b1;
         frame_tick_q  <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         wrap_q        <= wrap;
         disp_q        <= disp_d;
         pend_q        <= pend_d;
         pend_valid_q  <= pend_valid_d;
         sel_q         <= sel_d;
         out_q         <= out_d;
         blank_q       <= blank_d;
         // Delayed twice so the pulse lines up with the first registered digit-0 output
         frame_tick_q  <= wrap_q;
      end
   end

   assign digit_select = sel_q;
   assign out          = out_q;
   assign blank        = blank_q;
   assign frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] code_in;
   logic        load;
   logic        blank_lz;
   logic [3:0]  blink_mask;
   logic [3:0]  digit_select;
   logic [3:0]  out;
   logic        blank;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;
   int frame_no = 0;

   display_scan_ctrl #(
      .NUM_DIGITS     (4),
      .PRESCALE       (4),
      .BLINK_DIV      (2),
      .SEL_ACTIVE_LOW (1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .code_in      (code_in),
      .load         (load),
      .blank_lz     (blank_lz),
      .blink_mask   (blink_mask),
      .digit_select (digit_select),
      .out          (out),
      .blank        (blank),
      .frame_tick   (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int j, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s frame %0d step %0d: got %b expected %b", tag, frame_no, j, got, exp);
      end
   endtask

   // Runs one 16-cycle frame starting with the scan at digit 0, presc 0. Optional loads are
   // driven in the cycle ending at step la / lb (step 15 is the wrap cycle).
   task automatic run_frame(input logic [15:0] exp_disp, input logic [3:0] exp_lz,
                            input logic exp_ft0,
                            input int la, input logic [15:0] va,
                            input int lb, input logic [15:0] vb);
      logic [3:0] one;
      logic [3:0] blink_exp;
      logic       phase;
      int         d;
      one       = 4'b0001;
      phase     = ((frame_no / 2) % 2) == 1;
      blink_exp = blink_mask & {4{phase}};
      for (int j = 0; j < 16; j++) begin
         load    = (j == la) || (j == lb);
         code_in = (j == lb) ? vb : va;
         @(posedge clk);
         #1;
         load = 1'b0;
         d    = j / 4;
         chk("sel", j, digit_select, ~(one << d));
         chk("out", j, out, exp_disp[4*d +: 4]);
         chk("blank", j, {3'b0, blank}, {3'b0, exp_lz[d] | blink_exp[d]});
         chk("frame_tick", j, {3'b0, frame_tick}, {3'b0, (j == 0) && exp_ft0});
      end
      frame_no++;
   endtask

   initial begin
      reset      = 1'b1;
      code_in    = 16'h0;
      load       = 1'b0;
      blank_lz   = 1'b0;
      blink_mask = 4'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel", 0, digit_select, 4'b1111);
      chk("rst_out", 0, out, 4'h0);
      chk("rst_blank", 0, {3'b0, blank}, 4'd1);
      chk("rst_ft", 0, {3'b0, frame_tick}, 4'd0);

      // Scan sequence with zero data
      reset = 1'b0;
      run_frame(16'h0000, 4'b0000, 1'b0, -1, 16'h0, -1, 16'h0);
      run_frame(16'h0000, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0);

      // Mid-frame load held until the wrap
      run_frame(16'h0000, 4'b0000, 1'b1, 5, 16'h1234, -1, 16'h0);
      run_frame(16'h1234, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0);

      // Pending load overridden by a load on the wrap cycle; pending must not resurface
      run_frame(16'h1234, 4'b0000, 1'b1, 3, 16'h1111, 15, 16'h2222);
      run_frame(16'h2222, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0);
      // Last of two mid-frame loads wins
      run_frame(16'h2222, 4'b0000, 1'b1, 2, 16'h0111, 9, 16'h0050);

      // Leading-zero blanking
      blank_lz = 1'b1;
      run_frame(16'h0050, 4'b1100, 1'b1, 4, 16'h0000, -1, 16'h0);
      run_frame(16'h0000, 4'b1110, 1'b1, 15, 16'h0A00, -1, 16'h0);
      run_frame(16'h0A00, 4'b1000, 1'b1, -1, 16'h0, -1, 16'h0);

      // Blink on digit 0: frames 10,11 blank, 12,13 shown
      blank_lz   = 1'b0;
      blink_mask = 4'b0001;
      run_frame(16'h0A00, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0);
      run_frame(16'h0A00, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0);
      run_frame(16'h0A00, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0);
      run_frame(16'h0A00, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0);

      // Reset during digit 2 with a pending load
      blink_mask = 4'b0;
      for (int j = 0; j < 9; j++) begin
         load    = (j == 1);
         code_in = 16'h5555;
         @(posedge clk);
         #1;
      end
      load  = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_sel", 0, digit_select, 4'b1111);
      chk("mid_rst_out", 0, out, 4'h0);
      chk("mid_rst_blank", 0, {3'b0, blank}, 4'd1);
      chk("mid_rst_ft", 0, {3'b0, frame_tick}, 4'd0);
      reset    = 1'b0;
      frame_no = 0;
      run_frame(16'h0000, 4'b0000, 1'b0, -1, 16'h0, -1, 16'h0);
      run_frame(16'h0000, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
